cla_seq_adder: RTL and testbench

Multi-cycle wide adder/subtractor controller that time-shares one SLICE-bit two-level carry-lookahead adder across WIDTH-bit operands. It latches an operation through a valid/ready handshake and sequences the slice adder from LSB to MSB, registering the inter-slice carry. It presents the full result with carry-out and signed overflow on a held output handshake. It sits between an operand source, such as a register file or accumulator front-end, and a result consumer, and it is the first sequential user of the 4-bit CLA group logic.

---
 rtl/cla_seq_adder.sv | 102 ++++++++++
 tb/tb_cla_seq_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle WIDTH-bit add/sub sharing one SLICE-bit two-level CLA slice
module cla_seq_adder #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NS = WIDTH / SLICE;
  localparam int NG = SLICE / 4;
  localparam int IW = NS > 1 ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic              carry_reg;
  logic [WIDTH-1:0]  a_reg, b_reg, acc, acc_next;
  logic [SLICE-1:0]  sp, sg, c, s;
  logic              cc, msb_c, last;

  // carries into bits 3..0 of a 4-bit group from its generate/propagate and carry-in
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
    cla4 = {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c0,
            g[1] | p[1] & g[0] | p[1] & p[0] & c0,
            g[0] | p[0] & c0,
            c0};
  endfunction

  // operands shift right each RUN cycle so the active slice is always the low SLICE bits
  always_comb begin
    sp = a_reg[SLICE-1:0] ^ b_reg[SLICE-1:0];
    sg = a_reg[SLICE-1:0] & b_reg[SLICE-1:0];
    c = '0;
    cc = carry_reg;
    for (int k = 0; k < NG; k++) begin
      c[4*k +: 4] = cla4(sg[4*k +: 4], sp[4*k +: 4], cc);
      cc = sg[4*k+3] | sp[4*k+3] & sg[4*k+2] | sp[4*k+3] & sp[4*k+2] & sg[4*k+1]
         | sp[4*k+3] & sp[4*k+2] & sp[4*k+1] & sg[4*k]
         | (&sp[4*k +: 4]) & cc;
    end
    s = sp ^ c;
    msb_c = c[SLICE-1];
    acc_next = (acc >> SLICE) | (WIDTH'(s) << (WIDTH - SLICE));
    last = idx == IW'(NS - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      carry_reg <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      acc <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= sub ? ~b : b;
          carry_reg <= sub | cin;
          idx <= '0;
          state <= RUN;
        end
        RUN: begin
          a_reg <= a_reg >> SLICE;
          b_reg <= b_reg >> SLICE;
          acc <= acc_next;
          carry_reg <= cc;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            sum <= acc_next;
            cout <= cc;
            ovf <= cc ^ msb_c;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed table, corner sequences and random ops against an arithmetic model
module tb_cla_seq_adder;
  localparam int W = 64;
  localparam int NS = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0, sub = 1'b0;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout, ovf, busy;

  int total = 0;
  int bad = 0;

  cla_seq_adder #(.WIDTH(W), .SLICE(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference: plain (W+1)-bit arithmetic, overflow from operand/result signs
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic         v;
    yy = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sb ? 1'b1 : ci};
    v = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                        input logic ts, output logic [W-1:0] rs, output logic rc,
                        output logic ro, output int lat);
    @(negedge clk);
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    rs = sum; rc = cout; ro = ovf;
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_sum"}, sum, 64'd0);
    chk({tag, "_cout"}, {63'd0, cout}, 64'd0);
    chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
  endtask

  initial begin
    vec_t vt[6];
    logic [W-1:0] rs, prev;
    logic         rc, ro;
    logic [W+1:0] m;
    int           lat;

    vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    vt[1] = '{64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vt[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vt[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vt[5] = '{64'h0000_0000_0000_1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0};

    #3 chk_reset_outs("reset_during");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("reset_after");

    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d_latency", i), lat, NS);
      chk($sformatf("vec%0d_sum", i), rs, vt[i].s);
      chk($sformatf("vec%0d_cout", i), {63'd0, rc}, {63'd0, vt[i].co});
      chk($sformatf("vec%0d_ovf", i), {63'd0, ro}, {63'd0, vt[i].ov});
      release_out();
    end

    // backpressure: result must hold while inputs churn
    run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, rs, rc, ro, lat);
    m = model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_sum", sum, m[W-1:0]);
      chk("bp_cout", {63'd0, cout}, {63'd0, m[W]});
      chk("bp_ovf", {63'd0, ovf}, {63'd0, m[W+1]});
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_busy", {63'd0, busy}, 64'd1);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      in_valid = ~in_valid;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = $urandom_range(0, 1);
    end
    in_valid = 1'b0;
    release_out();

    // reset two RUN edges into an op: no result, outputs cleared
    @(negedge clk);
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    prev = m[W-1:0];
    @(posedge clk);
    #1 chk("hold_in_run", sum, prev);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outs("reset_midrun");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrun_no_valid", {63'd0, out_valid}, 64'd0);
    end
    rst_n = 1'b1;
    run_op(64'h1234, 64'h4321, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("post_reset_latency", lat, NS);
    chk("post_reset_sum", rs, 64'h5555);
    chk("post_reset_cout", {63'd0, rc}, 64'd0);
    release_out();

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rci, rsb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 8 == 0) rb = ~ra;
      if (i % 8 == 1) rb = ra;
      rci = $urandom_range(0, 1);
      rsb = $urandom_range(0, 1);
      m = model(ra, rb, rci, rsb);
      run_op(ra, rb, rci, rsb, rs, rc, ro, lat);
      chk($sformatf("rand%0d_latency", i), lat, NS);
      chk($sformatf("rand%0d_sum", i), rs, m[W-1:0]);
      chk($sformatf("rand%0d_cout", i), {63'd0, rc}, {63'd0, m[W]});
      chk($sformatf("rand%0d_ovf", i), {63'd0, ro}, {63'd0, m[W+1]});
      release_out();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
